// File: rtl/spartan_arbiter.sv
// Four-master, one-slave Spartan bus arbiter: round-robin, locked for a full
// request packet plus its matching response packet, one transaction in flight.
module spartan_arbiter #(
  parameter int BWIDTH = 64
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [4*(BWIDTH+2)-1:0] SpMBUS_M,
  input  logic [3:0]              SpMVLD_M,
  output logic [3:0]              SpMRDY_M,
  output logic [BWIDTH+1:0]       SpSBUS_M,
  output logic [3:0]              SpSVLD_M,
  input  logic [3:0]              SpSRDY_M,
  output logic [BWIDTH+1:0]       SpMBUS_S,
  output logic                    SpMVLD_S,
  input  logic                    SpMRDY_S,
  input  logic [BWIDTH+1:0]       SpSBUS_S,
  input  logic                    SpSVLD_S,
  output logic                    SpSRDY_S,
  output logic [3:0]              GNT
);

  localparam int BW = BWIDTH + 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RSP  = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_next;
  logic [3:0] r_gnt;
  logic [3:0] w_gnt_next;
  logic [1:0] r_last;
  logic [1:0] w_last_next;

  logic [3:0]    w_rot_req;
  logic [1:0]    w_rot_idx;
  logic          w_any_req;
  logic [1:0]    w_winner;
  logic [BW-1:0] w_req_slice [4];
  logic [BW-1:0] w_req_beat;
  logic          w_in_req;
  logic          w_in_rsp;
  logic          w_mvld_g;
  logic          w_srdy_g;
  logic          w_req_xfer;
  logic          w_rsp_xfer;

  assign w_in_req = (r_state == S_REQ);
  assign w_in_rsp = (r_state == S_RSP);

  // Requests rotated so bit 0 is the master just after the previous winner.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_master
      assign w_rot_req[gi]   = SpMVLD_M[r_last + 2'(gi + 1)];
      assign w_req_slice[gi] = SpMBUS_M[gi*BW +: BW] & {BW{r_gnt[gi]}};
      assign SpMRDY_M[gi]    = w_in_req & r_gnt[gi] & SpMRDY_S;
      assign SpSVLD_M[gi]    = w_in_rsp & r_gnt[gi] & SpSVLD_S;
    end
  endgenerate

  assign w_any_req = |w_rot_req;

  always_comb begin
    w_rot_idx = 2'd3;
    if (w_rot_req[0])      w_rot_idx = 2'd0;
    else if (w_rot_req[1]) w_rot_idx = 2'd1;
    else if (w_rot_req[2]) w_rot_idx = 2'd2;
  end

  assign w_winner = r_last + 2'd1 + w_rot_idx;

  // Grant is one-hot, so an AND-OR mux selects the owner's request beat.
  always_comb begin
    w_req_beat = '0;
    for (int i = 0; i < 4; i++) begin
      w_req_beat = w_req_beat | w_req_slice[i];
    end
  end

  assign w_mvld_g   = |(SpMVLD_M & r_gnt);
  assign w_srdy_g   = |(SpSRDY_M & r_gnt);
  assign w_req_xfer = w_in_req & w_mvld_g & SpMRDY_S;
  assign w_rsp_xfer = w_in_rsp & SpSVLD_S & w_srdy_g;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_gnt   <= 4'b0000;
      r_last  <= 2'd3;
    end else begin
      r_state <= w_state_next;
      r_gnt   <= w_gnt_next;
      r_last  <= w_last_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_gnt_next   = r_gnt;
    w_last_next  = r_last;
    case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          w_state_next = S_REQ;
          w_gnt_next   = 4'b0001 << w_winner;
          w_last_next  = w_winner;
        end
      end
      S_REQ: begin
        if (w_req_xfer && w_req_beat[BW-1]) begin
          w_state_next = S_RSP;
        end
      end
      S_RSP: begin
        if (w_rsp_xfer && SpSBUS_S[BW-1]) begin
          w_state_next = S_IDLE;
          w_gnt_next   = 4'b0000;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_gnt_next   = 4'b0000;
      end
    endcase
  end

  // Slave responses outside RSP see SpSRDY_S=0 and simply wait.
  assign SpMBUS_S = w_in_req ? w_req_beat : '0;
  assign SpMVLD_S = w_in_req & w_mvld_g;
  assign SpSBUS_M = w_in_rsp ? SpSBUS_S : '0;
  assign SpSRDY_S = w_in_rsp & w_srdy_g;
  assign GNT      = r_gnt;

endmodule

// File: tb/tb_spartan_arbiter.sv
// Self-checking bench for spartan_arbiter: randomized masters and slave against
// a transaction-level ownership model with per-master packet queues.
module tb_spartan_arbiter;
  localparam int BWIDTH = 64;
  localparam int BW = BWIDTH + 2;
  typedef logic [BW-1:0] beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [4*BW-1:0] mbus_m;
  logic [3:0]      mvld_m;
  logic [3:0]      srdy_m;
  logic            mrdy_s;
  logic            svld_s;
  beat_t           sbus_s;
  logic [3:0]      SpMRDY_M;
  beat_t           SpSBUS_M;
  logic [3:0]      SpSVLD_M;
  beat_t           SpMBUS_S;
  logic            SpMVLD_S;
  logic            SpSRDY_S;
  logic [3:0]      GNT;

  spartan_arbiter #(.BWIDTH(BWIDTH)) dut (
    .CLK(clk), .RST(rst),
    .SpMBUS_M(mbus_m), .SpMVLD_M(mvld_m), .SpMRDY_M(SpMRDY_M),
    .SpSBUS_M(SpSBUS_M), .SpSVLD_M(SpSVLD_M), .SpSRDY_M(srdy_m),
    .SpMBUS_S(SpMBUS_S), .SpMVLD_S(SpMVLD_S), .SpMRDY_S(mrdy_s),
    .SpSBUS_S(sbus_s), .SpSVLD_S(svld_s), .SpSRDY_S(SpSRDY_S),
    .GNT(GNT)
  );

  int checks = 0;
  int errors = 0;

  // Transaction-level model: pending request beats per master, the slave's
  // pending response, and which master (if any) currently owns the slave.
  beat_t req_q [4][$];
  beat_t sl_q [$];
  int    owner;
  int    last;
  bit    in_rsp;
  bit [3:0] vld_hold;
  bit [3:0] vld_mask;
  bit    svld_hold;
  bit    prev_stall;
  beat_t prev_bus;
  int    p_vld, p_mrdy, p_srdy, p_svld, rsp_len_cfg;
  bit    early_rsp;
  bit    rst_drive;
  int    done, req_beats, rsp_beats;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) req_q[i].delete();
    sl_q.delete();
    owner = -1;
    last = 3;
    in_rsp = 0;
    vld_hold = '0;
    svld_hold = 0;
    prev_stall = 0;
  endtask

  task automatic add_pkt(input int m, input int len);
    beat_t b;
    for (int j = 0; j < len; j++) begin
      b[BWIDTH-1:0] = {$urandom, $urandom};
      b[BWIDTH] = (j == 0);
      b[BW-1] = (j == len - 1);
      req_q[m].push_back(b);
    end
  endtask

  task automatic gen_rsp();
    beat_t b;
    int len;
    len = (rsp_len_cfg > 0) ? rsp_len_cfg : int'($urandom_range(3, 1));
    for (int j = 0; j < len; j++) begin
      b[BWIDTH-1:0] = {$urandom, $urandom};
      b[BWIDTH] = (j == 0);
      b[BW-1] = (j == len - 1);
      sl_q.push_back(b);
    end
  endtask

  // One clock cycle: drive at posedge+1, check at posedge+2, advance model at edge.
  task automatic step();
    logic [3:0] v;
    logic [3:0] exp_gnt;
    bit rx, sx;
    int g, w;
    beat_t b;
    for (int i = 0; i < 4; i++) begin
      if (req_q[i].size() == 0 || !vld_mask[i]) v[i] = 1'b0;
      else if (vld_hold[i]) v[i] = 1'b1;
      else v[i] = (int'($urandom_range(99)) < p_vld);
      mbus_m[i*BW +: BW] = (req_q[i].size() > 0) ? req_q[i][0] : '0;
    end
    mvld_m = v;
    mrdy_s = (int'($urandom_range(99)) < p_mrdy);
    for (int i = 0; i < 4; i++) srdy_m[i] = (int'($urandom_range(99)) < p_srdy);
    svld_s = (sl_q.size() > 0) && (svld_hold || (int'($urandom_range(99)) < p_svld));
    sbus_s = (sl_q.size() > 0) ? sl_q[0] : '0;
    rst = rst_drive;
    #1;
    g = owner;
    exp_gnt = '0;
    if (g >= 0) exp_gnt[g] = 1'b1;
    checks++;
    if (GNT !== exp_gnt) begin
      errors++; $display("FAIL gnt: got %b want %b", GNT, exp_gnt);
    end
    checks++;
    if ($countones(GNT) > 1) begin
      errors++; $display("FAIL gnt_onehot: got %b want at most one bit", GNT);
    end
    if (g < 0) begin
      checks++;
      if ({SpMRDY_M, SpSVLD_M, SpMVLD_S, SpSRDY_S} !== 10'b0) begin
        errors++; $display("FAIL idle_ctl: got mrdy=%b svld=%b mvld_s=%b srdy_s=%b want all 0",
                           SpMRDY_M, SpSVLD_M, SpMVLD_S, SpSRDY_S);
      end
      checks++;
      if (SpMBUS_S !== '0 || SpSBUS_M !== '0) begin
        errors++; $display("FAIL idle_data: got mbus_s=%h sbus_m=%h want 0", SpMBUS_S, SpSBUS_M);
      end
    end else if (!in_rsp) begin
      checks++;
      if (SpMVLD_S !== v[g] || SpMRDY_M !== (mrdy_s ? exp_gnt : 4'b0)) begin
        errors++; $display("FAIL req_ctl: got mvld_s=%b mrdy_m=%b want %b %b",
                           SpMVLD_S, SpMRDY_M, v[g], (mrdy_s ? exp_gnt : 4'b0));
      end
      checks++;
      if (SpMBUS_S !== mbus_m[g*BW +: BW]) begin
        errors++; $display("FAIL req_data: got %h want %h", SpMBUS_S, mbus_m[g*BW +: BW]);
      end
      checks++;
      if (SpSRDY_S !== 1'b0 || SpSVLD_M !== 4'b0 || SpSBUS_M !== '0) begin
        errors++; $display("FAIL req_rsp_gate: got srdy_s=%b svld_m=%b sbus_m=%h want 0",
                           SpSRDY_S, SpSVLD_M, SpSBUS_M);
      end
      if (prev_stall) begin
        checks++;
        if (SpMVLD_S !== 1'b1 || SpMBUS_S !== prev_bus) begin
          errors++; $display("FAIL stall_stable: got vld=%b bus=%h want 1 %h", SpMVLD_S, SpMBUS_S, prev_bus);
        end
      end
    end else begin
      checks++;
      if (SpSVLD_M !== (svld_s ? exp_gnt : 4'b0) || SpSRDY_S !== srdy_m[g]) begin
        errors++; $display("FAIL rsp_ctl: got svld_m=%b srdy_s=%b want %b %b",
                           SpSVLD_M, SpSRDY_S, (svld_s ? exp_gnt : 4'b0), srdy_m[g]);
      end
      checks++;
      if (SpSBUS_M !== sbus_s) begin
        errors++; $display("FAIL rsp_data: got %h want %h", SpSBUS_M, sbus_s);
      end
      checks++;
      if (SpMRDY_M !== 4'b0 || SpMVLD_S !== 1'b0 || SpMBUS_S !== '0) begin
        errors++; $display("FAIL rsp_req_gate: got mrdy_m=%b mvld_s=%b mbus_s=%h want 0",
                           SpMRDY_M, SpMVLD_S, SpMBUS_S);
      end
    end
    rx = (g >= 0) && !in_rsp && v[g] && mrdy_s;
    sx = (g >= 0) && in_rsp && svld_s && srdy_m[g];
    if (rx) begin
      checks++;
      if (SpMBUS_S !== req_q[g][0]) begin
        errors++; $display("FAIL sb_req: got %h want %h", SpMBUS_S, req_q[g][0]);
      end
    end
    if (sx) begin
      checks++;
      if (SpSBUS_M !== sl_q[0]) begin
        errors++; $display("FAIL sb_rsp: got %h want %h", SpSBUS_M, sl_q[0]);
      end
    end
    prev_stall = (g >= 0) && !in_rsp && v[g] && !mrdy_s;
    prev_bus = SpMBUS_S;
    for (int i = 0; i < 4; i++) vld_hold[i] = v[i] && !(rx && i == g);
    svld_hold = svld_s && !sx;
    @(posedge clk);
    if (rst_drive) begin
      model_reset();
    end else if (g < 0) begin
      w = -1;
      for (int k = 1; k <= 4; k++) if (w < 0 && v[(last + k) % 4]) w = (last + k) % 4;
      if (w >= 0) begin
        owner = w;
        last = w;
        in_rsp = 0;
        if (early_rsp) gen_rsp();
      end
    end else if (rx) begin
      b = req_q[g].pop_front();
      req_beats++;
      if (b[BW-1]) begin
        in_rsp = 1;
        if (!early_rsp) gen_rsp();
      end
    end else if (sx) begin
      b = sl_q.pop_front();
      rsp_beats++;
      if (b[BW-1]) begin
        owner = -1;
        done++;
      end
    end
    #1;
  endtask

  task automatic reset_step();
    rst_drive = 1;
    step();
    rst_drive = 0;
    done = 0;
  endtask

  task automatic set_probs(input int pv, input int pm, input int ps, input int psv);
    p_vld = pv; p_mrdy = pm; p_srdy = ps; p_svld = psv;
  endtask

  task automatic test_reset();
    rst = 1; mvld_m = 4'hF; mrdy_s = 1; srdy_m = 4'hF; svld_s = 1;
    mbus_m = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    sbus_s = {$urandom, $urandom, $urandom};
    @(posedge clk); #1;
    checks++;
    if (GNT !== 4'b0) begin errors++; $display("FAIL reset_gnt: got %b want 0000", GNT); end
    checks++;
    if ({SpMRDY_M, SpSVLD_M, SpMVLD_S, SpSRDY_S} !== 10'b0) begin
      errors++; $display("FAIL reset_ctl: got %b want 0", {SpMRDY_M, SpSVLD_M, SpMVLD_S, SpSRDY_S});
    end
    checks++;
    if (SpMBUS_S !== '0 || SpSBUS_M !== '0) begin
      errors++; $display("FAIL reset_data: got %h %h want 0", SpMBUS_S, SpSBUS_M);
    end
    rst = 0;
    model_reset();
    done = 0;
  endtask

  task automatic test_single();
    int cyc, rb, sb;
    set_probs(100, 100, 100, 100);
    rsp_len_cfg = 2;
    rb = req_beats; sb = rsp_beats;
    add_pkt(2, 3);
    step();
    checks++;
    if (GNT !== 4'b0100) begin errors++; $display("FAIL single_grant: got %b want 0100", GNT); end
    cyc = 0;
    while (done == 0 && cyc < 50) begin
      step(); cyc++;
      checks++;
      if ((SpSVLD_M & 4'b1011) !== 4'b0) begin
        errors++; $display("FAIL single_svld: got %b want only bit 2", SpSVLD_M);
      end
    end
    checks++;
    if (done != 1) begin errors++; $display("FAIL single_done: got %0d want 1", done); end
    checks++;
    if (GNT !== 4'b0) begin errors++; $display("FAIL single_release: got %b want 0000", GNT); end
    checks++;
    if (req_beats - rb != 3 || rsp_beats - sb != 2) begin
      errors++; $display("FAIL single_beats: got req=%0d rsp=%0d want 3 2", req_beats - rb, rsp_beats - sb);
    end
  endtask

  task automatic test_rotation();
    logic [3:0] obs [$];
    logic [3:0] prev_g;
    int exp_seq [6] = '{0, 1, 2, 3, 0, 1};
    int cyc;
    reset_step();
    set_probs(100, 100, 100, 100);
    rsp_len_cfg = 1;
    for (int r = 0; r < 3; r++) for (int m = 0; m < 4; m++) add_pkt(m, 1);
    prev_g = 4'b0;
    cyc = 0;
    while (done < 6 && cyc < 200) begin
      step(); cyc++;
      if (GNT !== 4'b0 && prev_g === 4'b0) obs.push_back(GNT);
      prev_g = GNT;
    end
    checks++;
    if (obs.size() < 6) begin
      errors++; $display("FAIL rot_count: got %0d want 6", obs.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (obs[k] !== (4'b0001 << exp_seq[k])) begin
          errors++; $display("FAIL rot_order[%0d]: got %b want master %0d", k, obs[k], exp_seq[k]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int cyc, issued, m;
    reset_step();
    set_probs(60, 50, 50, 60);
    rsp_len_cfg = 0;
    issued = 0; cyc = 0;
    while (done < 1000 && cyc < 60000) begin
      if (issued < 1000) begin
        m = int'($urandom_range(3));
        if (req_q[m].size() < 8) begin
          add_pkt(m, int'($urandom_range(4, 1)));
          issued++;
        end
      end
      step(); cyc++;
    end
    checks++;
    if (done != 1000) begin errors++; $display("FAIL bp_done: got %0d want 1000", done); end
    checks++;
    if (req_q[0].size() + req_q[1].size() + req_q[2].size() + req_q[3].size() + sl_q.size() != 0) begin
      errors++; $display("FAIL bp_leftover: got %0d beats want 0",
                         req_q[0].size() + req_q[1].size() + req_q[2].size() + req_q[3].size() + sl_q.size());
    end
  endtask

  task automatic test_early_rsp();
    int cyc, early_seen;
    reset_step();
    set_probs(100, 30, 100, 100);
    rsp_len_cfg = 2;
    early_rsp = 1;
    add_pkt(0, 3);
    early_seen = 0; cyc = 0;
    while (done == 0 && cyc < 200) begin
      step(); cyc++;
      if (owner >= 0 && !in_rsp && svld_s) begin
        early_seen++;
        checks++;
        if (SpSRDY_S !== 1'b0 || SpSVLD_M !== 4'b0) begin
          errors++; $display("FAIL early_stall: got srdy_s=%b svld_m=%b want 0", SpSRDY_S, SpSVLD_M);
        end
      end
    end
    early_rsp = 0;
    checks++;
    if (early_seen == 0) begin errors++; $display("FAIL early_seen: got 0 want >0"); end
    checks++;
    if (done != 1) begin errors++; $display("FAIL early_done: got %0d want 1", done); end
  endtask

  task automatic test_mid_reset();
    int cyc;
    reset_step();
    set_probs(100, 100, 100, 100);
    rsp_len_cfg = 1;
    add_pkt(1, 4);
    step();
    checks++;
    if (GNT !== 4'b0010) begin errors++; $display("FAIL mrst_grant: got %b want 0010", GNT); end
    step();
    reset_step();
    checks++;
    if (GNT !== 4'b0) begin errors++; $display("FAIL mrst_gnt: got %b want 0000", GNT); end
    checks++;
    if ({SpMRDY_M, SpSVLD_M, SpMVLD_S, SpSRDY_S} !== 10'b0 || SpMBUS_S !== '0 || SpSBUS_M !== '0) begin
      errors++; $display("FAIL mrst_outputs: got ctl=%b mbus_s=%h want 0",
                         {SpMRDY_M, SpSVLD_M, SpMVLD_S, SpSRDY_S}, SpMBUS_S);
    end
    add_pkt(2, 1); add_pkt(1, 1); add_pkt(0, 1);
    step();
    checks++;
    if (GNT !== 4'b0001) begin errors++; $display("FAIL mrst_next: got %b want 0001", GNT); end
    cyc = 0;
    while (done < 3 && cyc < 100) begin step(); cyc++; end
    checks++;
    if (done != 3) begin errors++; $display("FAIL mrst_done: got %0d want 3", done); end
  endtask

  task automatic test_valid_gap();
    int cyc;
    reset_step();
    set_probs(100, 100, 100, 100);
    rsp_len_cfg = 2;
    add_pkt(1, 5);
    step(); step(); step();
    vld_mask[1] = 0;
    add_pkt(3, 2);
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (GNT !== 4'b0010 || SpMRDY_M[3] !== 1'b0) begin
        errors++; $display("FAIL gap_hold[%0d]: got gnt=%b mrdy3=%b want 0010 0", k, GNT, SpMRDY_M[3]);
      end
    end
    vld_mask[1] = 1;
    cyc = 0;
    while (done == 0 && cyc < 100) begin
      step(); cyc++;
      if (done == 0) begin
        checks++;
        if (GNT !== 4'b0010 || SpMRDY_M[3] !== 1'b0) begin
          errors++; $display("FAIL gap_lock: got gnt=%b mrdy3=%b want 0010 0", GNT, SpMRDY_M[3]);
        end
      end
    end
    checks++;
    if (done != 1) begin errors++; $display("FAIL gap_done: got %0d want 1", done); end
    step();
    checks++;
    if (GNT !== 4'b1000) begin errors++; $display("FAIL gap_next: got %b want 1000", GNT); end
  endtask

  initial begin
    rst = 1; mbus_m = '0; mvld_m = '0; srdy_m = '0; mrdy_s = 0; svld_s = 0; sbus_s = '0;
    model_reset();
    rst_drive = 0; early_rsp = 0; vld_mask = 4'hF;
    done = 0; req_beats = 0; rsp_beats = 0;
    set_probs(100, 100, 100, 100);
    rsp_len_cfg = 1;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_rotation();
    test_backpressure();
    test_early_rsp();
    test_mid_reset();
    test_valid_gap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spartan_arbiter.md
# spartan_arbiter

Four-master, one-slave arbiter for the Spartan bus. It shares one downstream Spartan slave port, typically a spartan_sync gasket in front of a shared peripheral, among four upstream masters. Arbitration is round-robin and packet-locked. The winning master keeps the slave for its whole request packet and the matching response packet, then the grant is released. One transaction is outstanding at a time, so no response tagging or reordering exists.

## Interface
- BWIDTH, 64, payload width; each bus beat is BWIDTH+2 bits, bit [BWIDTH+1] = EOP (last beat), bit [BWIDTH] = SOP (passed through, not interpreted).
- CLK  in  1  sole clock, all logic rising-edge.
- RST  in  1  reset, synchronous, active-high.
- SpMBUS_M  in  4*(BWIDTH+2)  master i request beat at slice [i*(BWIDTH+2) +: BWIDTH+2].
- SpMVLD_M  in  4  master i request valid.
- SpMRDY_M  out  4  master i request ready.
- SpSBUS_M  out  BWIDTH+2  response beat, broadcast to all masters.
- SpSVLD_M  out  4  master i response valid.
- SpSRDY_M  in  4  master i response ready.
- SpMBUS_S  out  BWIDTH+2  request beat to slave.
- SpMVLD_S  out  1  request valid to slave.
- SpMRDY_S  in  1  slave request ready.
- SpSBUS_S  in  BWIDTH+2  response beat from slave.
- SpSVLD_S  in  1  slave response valid.
- SpSRDY_S  out  1  response ready to slave.
- GNT  out  4  registered one-hot current grant; 0 in IDLE.

## Operation
- A beat transfers on a rising edge where VLD=1 and RDY=1. VLD may not depend on RDY.
- State machine: IDLE, REQ, RSP. Registers: state, gnt (one-hot), last (2-bit index of the most recent winner).
- IDLE
  - All SpMRDY_M, SpSVLD_M, SpMVLD_S and SpSRDY_S are 0.
  - If any SpMVLD_M bit is 1, the winner is the first set bit scanning from (last+1) mod 4 upward with wrap.
  - On that edge: gnt is set to the winner, last is set to the winner index, and the state moves to REQ.
- REQ
  - SpMBUS_S = granted slice, SpMVLD_S = SpMVLD_M[g], SpMRDY_M[g] = SpMRDY_S; all other SpMRDY_M bits are 0.
  - A transferred beat with EOP=1 moves the state to RSP.
  - The granted master may deassert valid mid-packet; the lock is held until EOP.
- RSP
  - SpSBUS_M = SpSBUS_S, SpSVLD_M[g] = SpSVLD_S, SpSRDY_S = SpSRDY_M[g]; all other SpSVLD_M bits are 0.
  - A transferred beat with EOP=1 moves the state to IDLE and clears gnt.
- Data output gating
  - SpMBUS_S is all-zero outside REQ.
  - SpSBUS_M is all-zero outside RSP.
- Slave response beats arriving in IDLE or REQ are stalled (SpSRDY_S=0), never dropped.
- Single-beat packets (SOP=EOP=1) are legal; REQ and RSP each last exactly one transfer.
- The datapath is purely combinational, with no data registers; only the control is registered.

## Timing
- Reset values: state=IDLE, gnt=0, last=3 (so master 0 has first priority). Every output is 0 in the cycle after reset.
- Reset mid-operation: IDLE on the next edge regardless of state. In-flight packets are abandoned, and no ready or valid is asserted the following cycle.
- Arbitration latency: a request seen in cycle n can transfer its first beat in cycle n+1 at the earliest.
- Release: the response EOP transfers in cycle m, the state is IDLE in m+1, and the next grant can be effective in m+2. The minimum gap is one idle cycle per transaction.
- Requests asserted while the arbiter is busy are held by the master, since ready is 0. They are evaluated at the next IDLE cycle.
- Fairness: with all four requesting continuously, grants rotate 0,1,2,3,0… Each master waits at most 3 transactions.
- Combinational paths: SpMRDY_S→SpMRDY_M, SpSRDY_M→SpSRDY_S, and valid/data passthrough. Callers insert spartan_sync for timing isolation.

## Test plan
- Reset then a single master: master 2 sends a 3-beat request (EOP on beat 3); the slave returns a 2-beat response. Required: GNT=4'b0100 one cycle after request; beats arrive at slave in order unchanged; SpSVLD_M=4'b0100 only; GNT=0 the cycle after response EOP.
- All four masters request continuously with single-beat packets. Required: grant order 0,1,2,3,0,1 and GNT never multi-hot.
- Backpressure: SpMRDY_S and SpSRDY_M[g] toggle pseudo-randomly at 50%. Required: no lost or duplicated beats, SpMVLD_S stable while stalled, scoreboard match over 1000 transactions.
- Early response: the slave asserts SpSVLD_S during REQ. Required: SpSRDY_S=0 until state is RSP, then the response is delivered intact.
- Mid-packet reset: assert RST for one cycle during beat 2 of a 4-beat request. Required: all outputs 0 the next cycle, GNT=0, and master 0 wins next if multiple masters request.
- Granted-master valid gap: master 1 drops valid for 3 cycles mid-packet while master 3 requests. Required: GNT stays 4'b0010 until master 1's EOP and response complete; SpMRDY_M[3]=0 throughout.
